// File: rtl/conv_feeder_if.sv
// AXI-Stream byte feed from the DMA into the conv operand feeder.
// The master is the DMA side, which drives data, valid and last.
// The slave is the feeder, which returns ready.
interface conv_feeder_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/conv_feeder.sv
// conv_feeder: unpacks a 32-bit stream frame into 72-bit 3x3 operand vectors.
// The first 9 bytes of a frame become the held weight vector.
// Every following 9 bytes form one patch. Each patch leaves together with the
// weights as a paired w_valid/p_valid pulse.
module conv_feeder #(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    conv_feeder_if.slave       s_axis,
    output logic [71:0]        w,
    output logic               w_valid,
    output logic [71:0]        p,
    output logic               p_valid,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   patch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_P = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t       state;
    logic [3:0]   fill;        // valid bytes in buf_q, 0..12
    logic [95:0]  buf_q;       // byte i = buf_q[8i+7:8i], byte 0 is the oldest
    logic [71:0]  w_hold;      // weights captured at the start of the frame
    logic         from_w;      // frame ended before its weights were complete
    logic         pair_vld;

    logic         acc;
    logic         ext;
    logic         last_acc;
    logic [127:0] cat;
    logic [71:0]  ext_bytes;
    logic [95:0]  buf_next;
    logic [3:0]   fill_next;

    // The stream is only open while a frame is being loaded.
    assign s_axis.tready = (state == LOAD_W) || (state == LOAD_P);
    assign acc           = s_axis.tvalid && s_axis.tready;
    assign last_acc      = acc && s_axis.tlast;
    // Any whole group of 9 bytes leaves the buffer in the same cycle it appears.
    assign ext           = (fill >= 4'd9);

    // Combine the append and the extraction into a single buffer update.
    // The new beat lands at index fill, which is at most 12. Indices 12..15 are
    // used only when a 9-byte group leaves in the same cycle, so the result
    // always fits in 12 bytes.
    always_comb begin
        cat = {32'd0, buf_q};
        if (acc) begin
            cat[{fill, 3'b000} +: 32] = s_axis.tdata;
        end
        ext_bytes = cat[71:0];
        buf_next  = ext ? 96'(cat >> 72) : cat[95:0];
        fill_next = fill + (acc ? 4'd4 : 4'd0) - (ext ? 4'd9 : 4'd0);
    end

    // The byte storage and the weight holding register need no reset.
    // Their contents only matter when the fill count or state qualify them.
    always_ff @(posedge clk) begin
        buf_q <= buf_next;
        if (state == LOAD_W && ext) begin
            w_hold <= ext_bytes;
        end
    end

    // Frame sequencing FSM. It owns the fill count and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fill      <= 4'd0;
            from_w    <= 1'b0;
            pair_vld  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            patch_cnt <= '0;
            w         <= '0;
            p         <= '0;
        end else begin
            pair_vld <= 1'b0;
            done     <= 1'b0;
            fill     <= fill_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_W;
                        patch_cnt <= '0;
                        err       <= 1'b0;
                        from_w    <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (ext) begin
                        // The weights are captured by the data block.
                        // A tlast arriving in this same cycle still ends the frame.
                        state <= last_acc ? FLUSH : LOAD_P;
                    end else if (last_acc) begin
                        state  <= FLUSH;
                        err    <= 1'b1;
                        from_w <= 1'b1;
                    end
                end
                LOAD_P: begin
                    if (ext) begin
                        p         <= ext_bytes;
                        w         <= w_hold;
                        pair_vld  <= 1'b1;
                        patch_cnt <= patch_cnt + CNT_W'(1);
                    end
                    if (last_acc) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (ext) begin
                        // A frame that never completed its weights only drains.
                        if (!from_w) begin
                            p         <= ext_bytes;
                            w         <= w_hold;
                            pair_vld  <= 1'b1;
                            patch_cnt <= patch_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (fill != 4'd0) begin
                            err <= 1'b1;
                        end
                        fill  <= 4'd0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_valid = pair_vld;
    assign p_valid = pair_vld;

    // Structural invariants of the byte buffer.
    fill_bounded: assert property (@(posedge clk) disable iff (rst) fill <= 4'd12);
    idle_empty:   assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> (fill == 4'd0));

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder.
// It applies directed frames and randomized frames, and checks them against a
// frame-level model.
module tb_conv_feeder;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [71:0]       w;
    logic              w_valid;
    logic [71:0]       p;
    logic              p_valid;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  patch_cnt;

    conv_feeder_if s_if ();

    conv_feeder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_axis    (s_if),
        .w         (w),
        .w_valid   (w_valid),
        .p         (p),
        .p_valid   (p_valid),
        .done      (done),
        .err       (err),
        .patch_cnt (patch_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [71:0] got_p[$];
    logic [71:0] got_w[$];
    int          done_cnt = 0;
    logic [7:0]  frame_b [0:63];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects pulses and checks w/p pairing.
    always @(negedge clk) begin
        if (!rst) begin
            if (p_valid || w_valid) begin
                chk("pair", w_valid, p_valid);
                if (p_valid) begin
                    got_p.push_back(p);
                    got_w.push_back(w);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_w"}, w, 0);
        chk({nm, "_p"}, p, 0);
        chk({nm, "_wv"}, w_valid, 0);
        chk({nm, "_pv"}, p_valid, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_cnt"}, patch_cnt, 0);
        chk({nm, "_tready"}, s_if.tready, 0);
    endtask

    // Drives one frame from frame_b.
    // gaps: 0 = back-to-back beats, 1 = idle cycle before every beat, 2 = random idles.
    // abort_after > 0 pulses rst once that many beats have been accepted.
    task automatic run_frame(input int nbeats, input int gaps, input int abort_after, input string nm);
        int          np;
        bit          exp_err;
        logic [71:0] ew;
        logic [71:0] ep;
        bit          ok;
        int          guard;
        int          idles;
        got_p.delete();
        got_w.delete();
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            idles = (gaps == 1) ? 1 : (gaps == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < idles; g++) begin
                s_if.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = {frame_b[4*b+3], frame_b[4*b+2], frame_b[4*b+1], frame_b[4*b]};
            s_if.tlast  = (b == nbeats - 1);
            start       = $urandom_range(0, 1);   // must be ignored mid-frame
            ok = 1'b0;
            guard = 0;
            while (!ok) begin
                @(negedge clk);
                ok = s_if.tready;
                @(posedge clk); #1;
                guard++;
                if (!ok && guard > 50) begin
                    chk({nm, "_hs_timeout"}, 0, 1);
                    break;
                end
            end
            start       = 1'b0;
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
            if (b + 1 == abort_after) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs({nm, "_abort"});
                rst = 1'b0;
                return;
            end
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        @(negedge clk);
        // Frame-level model: 9 weight bytes, then whole 9-byte patches.
        // A frame whose tlast lands at or before the 12-byte mark ends before
        // its weights are taken, so it is an error with no patches.
        if (nbeats <= 3) begin
            np = 0;
            exp_err = 1'b1;
        end else begin
            np = (4 * nbeats - 9) / 9;
            exp_err = ((4 * nbeats - 9) % 9) != 0;
        end
        chk({nm, "_done"}, done_cnt, 1);
        chk({nm, "_npulse"}, got_p.size(), np);
        chk({nm, "_cnt"}, patch_cnt, np);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_tready"}, s_if.tready, 0);
        for (int i = 0; i < 9; i++) ew[8*i +: 8] = frame_b[i];
        for (int k = 0; k < np && k < got_p.size(); k++) begin
            for (int i = 0; i < 9; i++) ep[8*i +: 8] = frame_b[9 + 9*k + i];
            chk($sformatf("%s_p%0d", nm, k), got_p[k], ep);
            chk($sformatf("%s_w%0d", nm, k), got_w[k], ew);
        end
        if (np > 0) begin
            chk({nm, "_p_hold"}, p, ep);
            chk({nm, "_w_hold"}, w, ew);
        end
    endtask

    task automatic load_frame_a();
        for (int i = 0; i < 64; i++) frame_b[i] = 8'(i + 1);
    endtask

    task automatic check_frame_a_consts(input string nm);
        if (got_p.size() == 3) begin
            chk({nm, "_w_const"}, got_w[0], 72'h090807060504030201);
            chk({nm, "_p0_const"}, got_p[0], 72'h1211100F0E0D0C0B0A);
            chk({nm, "_p2_const"}, got_p[2], 72'h24232221201F1E1D1C);
            chk({nm, "_w2_const"}, got_w[2], 72'h090807060504030201);
        end else begin
            chk({nm, "_const_count"}, got_p.size(), 3);
        end
    endtask

    initial begin
        s_if.tdata  = 32'hDEADBEEF;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst = 1'b0;
        // tvalid held high in IDLE must not be accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_tready", s_if.tready, 0);
        end
        s_if.tvalid = 1'b0;

        load_frame_a();
        run_frame(9, 0, 0, "frameA");
        check_frame_a_consts("frameA");

        run_frame(9, 1, 0, "frameA_gap");
        check_frame_a_consts("frameA_gap");

        run_frame(10, 0, 0, "bytes40");

        run_frame(2, 0, 0, "short8");

        run_frame(9, 0, 5, "abort");
        run_frame(9, 0, 0, "after_abort");
        check_frame_a_consts("after_abort");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 64; i++) frame_b[i] = 8'($urandom);
            run_frame(int'($urandom_range(1, 14)), 2, 0, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
